dual_issue_scheduler: RTL and testbench
=======================================

// Module: dual_issue_scheduler
// PURPOSE
//  Sits between the F/D latch (two instructions fetched per cycle on imem ports a/b) and the
//  D/X latch of the 2-wide pipeline. Decides each cycle whether the fetched pair co-issues to
//  slots a/b or must be split: slot a issues now, slot b one cycle later. While a split is in
//  progress it holds fetch. Also counts split events for performance debug.
// PARAMETERS
//  MULDIV_ALUOP_MUL  5'b00110  ALUop encoding of mul (single shared multdiv unit)
//  MULDIV_ALUOP_DIV  5'b00111  ALUop encoding of div
//  CNT_W             32        width of split_count performance counter
// PORTS
//  clock        in   1   master clock; all state updates on posedge
//  reset        in   1   synchronous, active-high
//  fd_insn_a    in   32  older instruction of fetched pair (imem port a)
//  fd_insn_b    in   32  younger instruction of fetched pair (imem port b)
//  fd_valid_a   in   1   fd_insn_a is a real instruction
//  fd_valid_b   in   1   fd_insn_b is a real instruction
//  dx_stall     in   1   downstream hold (load-use interlock); freezes scheduler
//  flush        in   1   branch/jump taken in X; kill everything not yet in D/X
//  iss_insn_a   out  32  instruction to D/X slot a (registered)
//  iss_valid_a  out  1   slot a valid
//  iss_insn_b   out  32  instruction to D/X slot b (registered)
//  iss_valid_b  out  1   slot b valid
//  fd_hold      out  1   combinational; 1 = F/D latch and PC must not advance
//  split_count  out  CNT_W  number of pairs split since reset (saturates at all-ones)
// BEHAVIOUR
//  Decode: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], ALUop[6:2]. R-type=00000,
//   addi=00101, sw=00111, lw=01000, j=00001, bne=00010, jal=00011, jr=00100, blt=00110,
//   bex=10110, setx=10101. sw/bne/blt/jr read rd as a source. Writer dest: R/addi/lw -> rd,
//   jal -> r31, setx -> r30, mul/div -> rd and r30. r0 as dest never counts as a write.
//  Split conditions (any true and both valid => split):
//   RAW: b reads a register a writes. WAW: a and b write same non-zero register.
//   Control: a is j/jal/jr/bne/blt/bex (b must not issue alongside an unresolved branch).
//   Structural: both are mul/div. Memory: both are lw/sw and at least one is sw.
//  FSM, 2 states, reset -> PAIR:
//   PAIR:  dx_stall=1 -> no change to outputs or state. Else if no split: issue a,b with
//          their valid bits; stay PAIR. Else split: issue a only (iss_valid_b=0), latch
//          fd_insn_b into b_pend, fd_hold=1, split_count+=1, -> SECOND.
//   SECOND: fd_hold=1. dx_stall=1 -> hold. Else issue b_pend in slot a, iss_valid_b=0,
//          fd_hold=0 this cycle (fetch advances), -> PAIR.
//  fd_hold = (state==PAIR && split && !flush) || (state==SECOND && dx_stall) ||
//            (state==PAIR && dx_stall); i.e. 0 only when F/D contents are fully consumed.
//  Latency: fetched pair visible on iss_* exactly one cycle after acceptance.
//  flush (priority over everything except reset): iss_valid_a=iss_valid_b=0 next cycle,
//   b_pend dropped, -> PAIR, fd_hold=0, split_count unchanged. flush with dx_stall: flush wins.
//  fd_valid_a=0 with fd_valid_b=1 is illegal from fetch; treat as pair with no split.
//  Invalid slot bits never cause a split; a lone valid instruction always issues in one cycle.
//  Reset: state=PAIR, iss_insn_a/b=0, iss_valid_a/b=0, b_pend=0, split_count=0, fd_hold=0.
//   Reset mid-SECOND discards b_pend.
//  split_count saturates at {CNT_W{1'b1}}, no wrap.
// STRUCTURE
//  Shared package/include (isa_defs): opcode constants, ALUop mul/div, r30/r31 indices,
//   field bit positions; reused by decode and hazard units.
//  One sub-module: pair_hazard_check (combinational; insn_a, insn_b, valids -> split). Top
//   holds FSM, b_pend, issue registers, counter.
// TESTING
//  1 add r1,r2,r3 | add r4,r5,r6 -> both issued next cycle, fd_hold=0, split_count=0.
//  2 addi r1,r0,5 | add r2,r1,r1 -> cycle1 slot a=addi only, fd_hold=1; cycle2 slot a=add;
//    split_count=1.
//  3 mul r1,r2,r3 | div r4,r5,r6 -> split; sw r1,0(r2) | lw r3,4(r4) -> split;
//    lw | lw -> pair.
//  4 split pair, dx_stall=1 for 3 cycles in SECOND -> iss_* frozen, fd_hold=1 throughout,
//    add issues first cycle after stall drops.
//  5 flush asserted in SECOND -> next cycle iss_valid_a=iss_valid_b=0, state PAIR,
//    b_pend never issued.
//  6 reset asserted in SECOND -> all outputs 0 next cycle; preload split_count=all-ones
//    then split -> stays all-ones.

Source files
------------

// File: rtl/dual_issue_scheduler_pkg.sv
// ISA field layout, opcode encodings and the per-instruction register-usage decode
// shared by the dual-issue scheduler and its pair hazard checker.
package dual_issue_scheduler_pkg;

   typedef enum logic [4:0] {
      OP_RTYPE = 5'b00000,
      OP_J     = 5'b00001,
      OP_BNE   = 5'b00010,
      OP_JAL   = 5'b00011,
      OP_JR    = 5'b00100,
      OP_ADDI  = 5'b00101,
      OP_BLT   = 5'b00110,
      OP_SW    = 5'b00111,
      OP_LW    = 5'b01000,
      OP_SETX  = 5'b10101,
      OP_BEX   = 5'b10110
   } opcode_e;

   localparam logic [4:0] ALUOP_MUL  = 5'b00110;
   localparam logic [4:0] ALUOP_DIV  = 5'b00111;
   localparam logic [4:0] REG_ZERO   = 5'd0;
   localparam logic [4:0] REG_STATUS = 5'd30;
   localparam logic [4:0] REG_RA     = 5'd31;

   localparam int unsigned OPC_LO = 27;
   localparam int unsigned RD_LO  = 22;
   localparam int unsigned RS_LO  = 17;
   localparam int unsigned RT_LO  = 12;
   localparam int unsigned ALU_LO = 2;

   typedef enum logic {
      ST_PAIR,
      ST_SECOND
   } sched_state_e;

   typedef struct packed {
      logic [4:0] src1;
      logic       src1_en;
      logic [4:0] src2;
      logic       src2_en;
      logic [4:0] dst1;
      logic       dst1_en;
      logic [4:0] dst2;
      logic       dst2_en;
      logic       is_ctrl;
      logic       is_muldiv;
      logic       is_mem;
      logic       is_store;
   } insn_info_t;

   function automatic insn_info_t decode_insn(input logic [31:0] insn,
                                              input logic [4:0]  mul_op,
                                              input logic [4:0]  div_op);
      insn_info_t info;
      logic [4:0] op, rd, rs, rt, alu;
      op  = insn[OPC_LO +: 5];
      rd  = insn[RD_LO  +: 5];
      rs  = insn[RS_LO  +: 5];
      rt  = insn[RT_LO  +: 5];
      alu = insn[ALU_LO +: 5];
      info = '0;
      case (op)
         OP_RTYPE: begin
            info.src1 = rs;  info.src1_en = 1'b1;
            info.src2 = rt;  info.src2_en = 1'b1;
            info.dst1 = rd;  info.dst1_en = 1'b1;
            if (alu == mul_op || alu == div_op) begin
               info.is_muldiv = 1'b1;
               info.dst2      = REG_STATUS;
               info.dst2_en   = 1'b1;
            end
         end
         OP_ADDI: begin
            info.src1 = rs;  info.src1_en = 1'b1;
            info.dst1 = rd;  info.dst1_en = 1'b1;
         end
         OP_LW: begin
            info.src1 = rs;  info.src1_en = 1'b1;
            info.dst1 = rd;  info.dst1_en = 1'b1;
            info.is_mem = 1'b1;
         end
         OP_SW: begin
            info.src1 = rs;  info.src1_en = 1'b1;
            info.src2 = rd;  info.src2_en = 1'b1;
            info.is_mem   = 1'b1;
            info.is_store = 1'b1;
         end
         OP_BNE, OP_BLT: begin
            info.src1 = rs;  info.src1_en = 1'b1;
            info.src2 = rd;  info.src2_en = 1'b1;
            info.is_ctrl = 1'b1;
         end
         OP_JR: begin
            info.src1 = rd;  info.src1_en = 1'b1;
            info.is_ctrl = 1'b1;
         end
         OP_J:    info.is_ctrl = 1'b1;
         OP_JAL: begin
            info.dst1 = REG_RA;  info.dst1_en = 1'b1;
            info.is_ctrl = 1'b1;
         end
         OP_BEX: begin
            info.src1 = REG_STATUS;  info.src1_en = 1'b1;
            info.is_ctrl = 1'b1;
         end
         OP_SETX: begin
            info.dst1 = REG_STATUS;  info.dst1_en = 1'b1;
         end
         default: ;
      endcase
      // r0 is hardwired, so a write to it can never create a dependence
      if (info.dst1 == REG_ZERO) info.dst1_en = 1'b0;
      return info;
   endfunction

endpackage

// File: rtl/dual_issue_scheduler_pair_hazard_check.sv
// Combinational check of whether a fetched pair can co-issue or must be split.
import dual_issue_scheduler_pkg::*;

module pair_hazard_check #(
   parameter logic [4:0] MULDIV_ALUOP_MUL = ALUOP_MUL,
   parameter logic [4:0] MULDIV_ALUOP_DIV = ALUOP_DIV
) (
   input  logic [31:0] insn_a,
   input  logic [31:0] insn_b,
   input  logic        valid_a,
   input  logic        valid_b,
   output logic        split
);

   insn_info_t info_a, info_b;
   logic raw, waw, ctrl, structural, memory;

   function automatic logic a_writes(input insn_info_t a, input logic [4:0] r);
      return (a.dst1_en && a.dst1 == r) || (a.dst2_en && a.dst2 == r);
   endfunction

   always_comb begin
      info_a = decode_insn(insn_a, MULDIV_ALUOP_MUL, MULDIV_ALUOP_DIV);
      info_b = decode_insn(insn_b, MULDIV_ALUOP_MUL, MULDIV_ALUOP_DIV);
      raw = (info_b.src1_en && a_writes(info_a, info_b.src1)) ||
            (info_b.src2_en && a_writes(info_a, info_b.src2));
      waw = (info_b.dst1_en && a_writes(info_a, info_b.dst1)) ||
            (info_b.dst2_en && a_writes(info_a, info_b.dst2));
      ctrl       = info_a.is_ctrl;
      structural = info_a.is_muldiv && info_b.is_muldiv;
      memory     = info_a.is_mem && info_b.is_mem && (info_a.is_store || info_b.is_store);
      split = valid_a && valid_b && (raw || waw || ctrl || structural || memory);
   end

endmodule

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler between F/D and D/X: co-issues a fetched pair or splits it
// over two cycles while holding fetch, and counts split events.
import dual_issue_scheduler_pkg::*;

module dual_issue_scheduler #(
   parameter logic [4:0]  MULDIV_ALUOP_MUL = 5'b00110,
   parameter logic [4:0]  MULDIV_ALUOP_DIV = 5'b00111,
   parameter int unsigned CNT_W            = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      fd_insn_a,
   input  logic [31:0]      fd_insn_b,
   input  logic             fd_valid_a,
   input  logic             fd_valid_b,
   input  logic             dx_stall,
   input  logic             flush,
   output logic [31:0]      iss_insn_a,
   output logic             iss_valid_a,
   output logic [31:0]      iss_insn_b,
   output logic             iss_valid_b,
   output logic             fd_hold,
   output logic [CNT_W-1:0] split_count
);

   sched_state_e state;
   logic [31:0]  b_pend;
   logic         split;

   pair_hazard_check #(
      .MULDIV_ALUOP_MUL(MULDIV_ALUOP_MUL),
      .MULDIV_ALUOP_DIV(MULDIV_ALUOP_DIV)
   ) u_hazard (
      .insn_a  (fd_insn_a),
      .insn_b  (fd_insn_b),
      .valid_a (fd_valid_a),
      .valid_b (fd_valid_b),
      .split   (split)
   );

   // A stall holds fetch in either state; flush (and reset) always release it.
   always_comb begin
      fd_hold = !reset && !flush && (dx_stall || (state == ST_PAIR && split));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_PAIR;
         iss_insn_a  <= '0;
         iss_valid_a <= 1'b0;
         iss_insn_b  <= '0;
         iss_valid_b <= 1'b0;
         b_pend      <= '0;
         split_count <= '0;
      end else if (flush) begin
         iss_valid_a <= 1'b0;
         iss_valid_b <= 1'b0;
         b_pend      <= '0;
         state       <= ST_PAIR;
      end else if (!dx_stall) begin
         case (state)
            ST_PAIR: begin
               iss_insn_a  <= fd_insn_a;
               iss_valid_a <= fd_valid_a;
               iss_insn_b  <= fd_insn_b;
               if (split) begin
                  iss_valid_b <= 1'b0;
                  b_pend      <= fd_insn_b;
                  state       <= ST_SECOND;
                  if (split_count != '1) split_count <= split_count + CNT_W'(1);
               end else begin
                  iss_valid_b <= fd_valid_b;
               end
            end
            ST_SECOND: begin
               iss_insn_a  <= b_pend;
               iss_valid_a <= 1'b1;
               iss_valid_b <= 1'b0;
               state       <= ST_PAIR;
            end
            default: state <= ST_PAIR;
         endcase
      end
   end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler: table-driven pairs through a
// per-cycle issue scoreboard, plus stall, flush, reset and saturation sequences.
module tb_dual_issue_scheduler;

   localparam int unsigned CW = 4;

   logic          clock = 1'b0;
   logic          reset, dx_stall, flush;
   logic [31:0]   fd_insn_a, fd_insn_b;
   logic          fd_valid_a, fd_valid_b;
   logic [31:0]   iss_insn_a, iss_insn_b;
   logic          iss_valid_a, iss_valid_b, fd_hold;
   logic [CW-1:0] split_count;

   dual_issue_scheduler #(
      .MULDIV_ALUOP_MUL(5'b00110),
      .MULDIV_ALUOP_DIV(5'b00111),
      .CNT_W(CW)
   ) dut (
      .clock(clock), .reset(reset),
      .fd_insn_a(fd_insn_a), .fd_insn_b(fd_insn_b),
      .fd_valid_a(fd_valid_a), .fd_valid_b(fd_valid_b),
      .dx_stall(dx_stall), .flush(flush),
      .iss_insn_a(iss_insn_a), .iss_valid_a(iss_valid_a),
      .iss_insn_b(iss_insn_b), .iss_valid_b(iss_valid_b),
      .fd_hold(fd_hold), .split_count(split_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] ia;
      logic        va;
      logic [31:0] ib;
      logic        vb;
   } iss_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        va;
      logic        vb;
      logic        split;
   } vec_t;

   iss_t    sb[$];
   iss_t    last;
   vec_t    vecs[16];
   int      checks = 0;
   int      errors = 0;
   int      exp_cnt = 0;

   function automatic logic [31:0] r_ins(input logic [4:0] rd, rs, rt, alu);
      return {5'b00000, rd, rs, rt, 5'd0, alu, 2'b00};
   endfunction
   function automatic logic [31:0] i_ins(input logic [4:0] op, rd, rs, input logic [16:0] imm);
      return {op, rd, rs, imm};
   endfunction
   function automatic iss_t mk(input logic [31:0] ia, input logic va,
                               input logic [31:0] ib, input logic vb);
      return {ia, va, ib, vb};
   endfunction
   function automatic vec_t mkv(input logic [31:0] a, b, input logic va, vb, s);
      return {a, b, va, vb, s};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic bump_cnt();
      if (exp_cnt < (1 << CW) - 1) exp_cnt++;
   endtask

   // Advance one clock and compare the issue registers against the scoreboard head.
   task automatic tick();
      iss_t e;
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         last = e;
         chk("iss_valid_a", iss_valid_a, e.va);
         chk("iss_valid_b", iss_valid_b, e.vb);
         if (e.va) chk("iss_insn_a", iss_insn_a, e.ia);
         if (e.vb) chk("iss_insn_b", iss_insn_b, e.ib);
      end
   endtask

   task automatic drive(input vec_t v);
      fd_insn_a = v.a;   fd_insn_b = v.b;
      fd_valid_a = v.va; fd_valid_b = v.vb;
      #1;
   endtask

   task automatic apply(input vec_t v);
      drive(v);
      chk("fd_hold_accept", fd_hold, v.split);
      if (v.split) begin
         sb.push_back(mk(v.a, 1'b1, v.b, 1'b0));
         sb.push_back(mk(v.b, 1'b1, 32'd0, 1'b0));
         bump_cnt();
         tick();
         chk("fd_hold_second", fd_hold, 1'b0);
         tick();
      end else begin
         sb.push_back(mk(v.a, v.va, v.b, v.vb));
         tick();
      end
      chk("split_count", split_count, exp_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] add1, add2, addi1, radd;
      add1  = r_ins(5'd1, 5'd2, 5'd3, 5'b00000);
      add2  = r_ins(5'd4, 5'd5, 5'd6, 5'b00000);
      addi1 = i_ins(5'b00101, 5'd1, 5'd0, 17'd5);
      radd  = r_ins(5'd2, 5'd1, 5'd1, 5'b00000);

      vecs[0]  = mkv(add1, add2, 1, 1, 0);
      vecs[1]  = mkv(addi1, radd, 1, 1, 1);
      vecs[2]  = mkv(r_ins(5'd1, 5'd2, 5'd3, 5'b00110), r_ins(5'd4, 5'd5, 5'd6, 5'b00111), 1, 1, 1);
      vecs[3]  = mkv(i_ins(5'b00111, 5'd1, 5'd2, 17'd0), i_ins(5'b01000, 5'd3, 5'd4, 17'd4), 1, 1, 1);
      vecs[4]  = mkv(i_ins(5'b01000, 5'd1, 5'd2, 17'd0), i_ins(5'b01000, 5'd3, 5'd4, 17'd4), 1, 1, 0);
      vecs[5]  = mkv(add1, r_ins(5'd1, 5'd4, 5'd5, 5'b00000), 1, 1, 1);
      vecs[6]  = mkv(r_ins(5'd0, 5'd2, 5'd3, 5'b00000), r_ins(5'd0, 5'd4, 5'd5, 5'b00000), 1, 1, 0);
      vecs[7]  = mkv({5'b00001, 27'd100}, add2, 1, 1, 1);
      vecs[8]  = mkv(add1, radd, 1, 0, 0);
      vecs[9]  = mkv(add1, radd, 0, 1, 0);
      vecs[10] = mkv(r_ins(5'd1, 5'd2, 5'd3, 5'b00110), r_ins(5'd5, 5'd30, 5'd6, 5'b00000), 1, 1, 1);
      vecs[11] = mkv({5'b10101, 27'd7}, i_ins(5'b00101, 5'd30, 5'd1, 17'd1), 1, 1, 1);
      vecs[12] = mkv(i_ins(5'b00111, 5'd1, 5'd2, 17'd0), add2, 1, 1, 0);
      vecs[13] = mkv(add1, i_ins(5'b00111, 5'd1, 5'd4, 17'd0), 1, 1, 1);
      vecs[14] = mkv(i_ins(5'b00010, 5'd1, 5'd2, 17'd8), add2, 1, 1, 1);
      vecs[15] = mkv(add1, r_ins(5'd4, 5'd5, 5'd6, 5'b00110), 1, 1, 0);

      reset = 1'b1; dx_stall = 1'b0; flush = 1'b0;
      fd_insn_a = '0; fd_insn_b = '0; fd_valid_a = 1'b0; fd_valid_b = 1'b0;
      tick(); tick();
      chk("rst_valid_a", iss_valid_a, 1'b0);
      chk("rst_valid_b", iss_valid_b, 1'b0);
      chk("rst_insn_a", iss_insn_a, 32'd0);
      chk("rst_insn_b", iss_insn_b, 32'd0);
      chk("rst_count", split_count, 0);
      chk("rst_fd_hold", fd_hold, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) apply(vecs[i]);

      // Stall while in PAIR: outputs frozen, fetch held, pair issues after release.
      dx_stall = 1'b1;
      drive(vecs[0]);
      chk("stall_pair_hold", fd_hold, 1'b1);
      sb.push_back(last);
      tick();
      dx_stall = 1'b0;
      #1;
      chk("stall_pair_release", fd_hold, 1'b0);
      sb.push_back(mk(add1, 1'b1, add2, 1'b1));
      tick();

      // Stall for three cycles in SECOND.
      drive(vecs[1]);
      chk("st2_accept_hold", fd_hold, 1'b1);
      sb.push_back(mk(addi1, 1'b1, 32'd0, 1'b0));
      bump_cnt();
      tick();
      dx_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("st2_hold", fd_hold, 1'b1);
         sb.push_back(mk(addi1, 1'b1, 32'd0, 1'b0));
         tick();
      end
      dx_stall = 1'b0;
      #1;
      chk("st2_release", fd_hold, 1'b0);
      sb.push_back(mk(radd, 1'b1, 32'd0, 1'b0));
      tick();
      chk("st2_count", split_count, exp_cnt);

      // Flush in SECOND: the pending slot-b instruction must never issue.
      drive(vecs[1]);
      sb.push_back(mk(addi1, 1'b1, 32'd0, 1'b0));
      bump_cnt();
      tick();
      flush = 1'b1;
      #1;
      chk("flush_fd_hold", fd_hold, 1'b0);
      sb.push_back(mk(32'd0, 1'b0, 32'd0, 1'b0));
      tick();
      flush = 1'b0;
      fd_valid_a = 1'b0; fd_valid_b = 1'b0;
      #1;
      chk("post_flush_hold", fd_hold, 1'b0);
      sb.push_back(mk(32'd0, 1'b0, 32'd0, 1'b0));
      sb.push_back(mk(32'd0, 1'b0, 32'd0, 1'b0));
      tick(); tick();
      chk("flush_count", split_count, exp_cnt);

      // Flush together with stall in PAIR: flush wins.
      drive(vecs[0]);
      dx_stall = 1'b1; flush = 1'b1;
      #1;
      chk("flush_stall_hold", fd_hold, 1'b0);
      sb.push_back(mk(32'd0, 1'b0, 32'd0, 1'b0));
      tick();
      dx_stall = 1'b0; flush = 1'b0;

      // Drive the counter into saturation and past it.
      for (int i = 0; i < 8; i++) apply(vecs[1]);
      chk("sat_count", split_count, (1 << CW) - 1);

      // Reset while in SECOND discards b_pend and clears everything.
      drive(vecs[1]);
      sb.push_back(mk(addi1, 1'b1, 32'd0, 1'b0));
      tick();
      reset = 1'b1;
      #1;
      chk("rst2_fd_hold", fd_hold, 1'b0);
      tick();
      chk("rst2_valid_a", iss_valid_a, 1'b0);
      chk("rst2_valid_b", iss_valid_b, 1'b0);
      chk("rst2_insn_a", iss_insn_a, 32'd0);
      chk("rst2_insn_b", iss_insn_b, 32'd0);
      chk("rst2_count", split_count, 0);
      reset = 1'b0;
      exp_cnt = 0;
      apply(vecs[0]);
      apply(vecs[2]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
